rle_encoder: RTL and testbench

Upstream companion to the image decompression stage: consumes a frame of binary pixels one per clock and produces the 16-bit run-length words that decompression expands (bit 15 = pixel value, bits 14:0 = run length). Output words are the same format and order as the word stream the decompressor reads, so one frame through this block followed by decompression reproduces the original image buffer. Sits between the pixel source (camera/IO capture) and the compressed-word store.

---
 rtl/rle_pkg.sv | 27 ++
 rtl/rle_word_reg.sv | 34 +++
 rtl/rle_encoder.sv | 125 ++++++++++++
 tb/tb_rle_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared run-length word format and encoder state definitions.
// The decompression side imports the same field constants.
package rle_pkg;

    localparam int RLE_CNT_W   = 15;
    localparam int RLE_MAX_RUN = 32767;
    localparam int RLE_BIT_POS = 15;
    localparam int RLE_CNT_MSB = 14;
    localparam int RLE_WORD_W  = RLE_BIT_POS + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } rle_state_t;

    function automatic logic [RLE_WORD_W-1:0] pack_word(input logic run_bit,
                                                        input logic [RLE_CNT_W-1:0] run_len);
        logic [RLE_WORD_W-1:0] w;
        w = '0;
        w[RLE_BIT_POS]     = run_bit;
        w[RLE_CNT_MSB:0]   = run_len;
        return w;
    endfunction

endpackage

// File: rtl/rle_word_reg.sv
// Output holding register for run-length words with valid/ready handshake.
// Reloads in the same cycle as an outgoing handshake, so there is no bubble.
module rle_word_reg
    import rle_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [RLE_WORD_W-1:0] load_word,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [RLE_WORD_W-1:0] out_word,
    output logic                  can_load,
    output logic                  fire
);

    assign can_load = !out_valid || out_ready;
    assign fire     = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_word  <= load_word;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_encoder.sv
// Binary-pixel run-length encoder producing {run_bit, run_len[14:0]} words.
// Optional feature macro: RLE_WORD_COUNT_EN adds the saturating word_cnt output.
module rle_encoder
    import rle_pkg::*;
#(
    parameter int FRAME_BITS = 16384
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [RLE_WORD_W-1:0] out_word,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
`ifdef RLE_WORD_COUNT_EN
    ,
    output logic [RLE_CNT_W-1:0]  word_cnt
`endif
);

    localparam int MAX_RUN = RLE_MAX_RUN;
    localparam int PIX_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_BITS - 1);

    rle_state_t           state;
    logic [PIX_W-1:0]     pix_cnt;
    logic                 run_bit;
    logic [RLE_CNT_W-1:0] run_len;
    logic                 accept;
    logic                 extend;
    logic                 load;
    logic                 can_load;
    logic                 fire;

    assign in_ready = (state == ST_RUN) && can_load;
    assign accept   = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        extend = (in_bit == run_bit) && (run_len < RLE_CNT_W'(MAX_RUN));
        load   = 1'b0;
        case (state)
            ST_RUN:   load = accept && (run_len != '0) && !extend;
            ST_FLUSH: load = can_load;
            default:  load = 1'b0;
        endcase
    end

    rle_word_reg u_word_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (pack_word(run_bit, run_len)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .can_load  (can_load),
        .fire      (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pix_cnt <= '0;
            run_bit <= 1'b0;
            run_len <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        pix_cnt <= '0;
                        run_len <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        pix_cnt <= pix_cnt + PIX_W'(1);
                        if (run_len != '0 && extend) begin
                            run_len <= run_len + RLE_CNT_W'(1);
                        end else begin
                            run_bit <= in_bit;
                            run_len <= RLE_CNT_W'(1);
                        end
                        if (pix_cnt == LAST_PIX) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (can_load) state <= ST_DONE;
                end
                ST_DONE: begin
                    // out_valid here can only be the final word of the frame.
                    if (fire) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RLE_WORD_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            word_cnt <= '0;
        end else if (fire && word_cnt != RLE_CNT_W'(MAX_RUN)) begin
            word_cnt <= word_cnt + RLE_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: three instances (16384, 40000, 16 pixel frames)
// exercised in parallel against hand-computed run-length words.
module tb_rle_encoder;

    logic        clk;
    logic        rst_n_s     [3];
    logic        start_s     [3];
    logic        in_valid_s  [3];
    logic        in_bit_s    [3];
    logic        in_ready_s  [3];
    logic        out_valid_s [3];
    logic [15:0] out_word_s  [3];
    logic        out_ready_s [3];
    logic        busy_s      [3];
    logic        done_s      [3];
`ifdef RLE_WORD_COUNT_EN
    logic [14:0] word_cnt_s  [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int cur_pat    [3];
    int n_words    [3];
    int sum_len    [3];
    int mis        [3];
    int zero_len   [3];
    int done_cnt   [3];
    int done_at    [3];
    int last_hs    [3];
    int stall_err  [3];
    int stall_seen [3];
    int rdy_err    [3];
    int bp_low     [3];
    logic        prev_stall [3];
    logic [15:0] prev_word  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rle_encoder #(.FRAME_BITS(g == 0 ? 16384 : (g == 1 ? 40000 : 16))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_s[g]),
            .start     (start_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_bit    (in_bit_s[g]),
            .in_ready  (in_ready_s[g]),
            .out_valid (out_valid_s[g]),
            .out_word  (out_word_s[g]),
            .out_ready (out_ready_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g])
`ifdef RLE_WORD_COUNT_EN
            ,
            .word_cnt  (word_cnt_s[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel patterns: 0 all zeros, 1 all ones, 2 alternating from 1, 3 eight ones then zeros.
    function automatic logic pix(input int pat, input int i);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (i % 2) == 0;
            default: return i < 8;
        endcase
    endfunction

    // Hand-derived word list per pattern; 0x0000 marks "no word expected here".
    function automatic logic [15:0] exp_word(input int pat, input int idx);
        case (pat)
            0:       return (idx == 0) ? 16'h4000 : 16'h0000;
            1:       return (idx == 0) ? 16'hFFFF : ((idx == 1) ? 16'h9C41 : 16'h0000);
            2:       return (idx < 16384) ? ((idx % 2 == 0) ? 16'h8001 : 16'h0001) : 16'h0000;
            default: return (idx == 0) ? 16'h8008 : ((idx == 1) ? 16'h0008 : 16'h0000);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n_s[d]) begin
                if (prev_stall[d]) begin
                    stall_seen[d]++;
                    if (!out_valid_s[d] || out_word_s[d] !== prev_word[d]) stall_err[d]++;
                end
                prev_stall[d] = out_valid_s[d] && !out_ready_s[d];
                prev_word[d]  = out_word_s[d];
                if (out_valid_s[d] && out_ready_s[d]) begin
                    if (out_word_s[d] !== exp_word(cur_pat[d], n_words[d])) mis[d]++;
                    if (out_word_s[d][14:0] == 15'd0) zero_len[d]++;
                    sum_len[d] += int'(out_word_s[d][14:0]);
                    n_words[d]++;
                    last_hs[d] = cyc;
                end
                if (done_s[d]) begin
                    done_cnt[d]++;
                    done_at[d] = cyc;
                end
            end else begin
                prev_stall[d] = 1'b0;
            end
        end
    end

    task automatic clear_stats(input int d);
        n_words[d] = 0; sum_len[d] = 0; mis[d] = 0; zero_len[d] = 0;
        done_cnt[d] = 0; done_at[d] = 0; last_hs[d] = 0;
        stall_err[d] = 0; stall_seen[d] = 0; rdy_err[d] = 0; bp_low[d] = 0;
    endtask

    // Runs one frame: start pulse, pixel feed honouring in_ready, optional 10-cycle
    // out_ready stall at pixel bp_at, optional extra start pulse at pixel start_at.
    task automatic run_frame(input int d, input int pat, input int nbits, input int bp_at,
                             input int start_at, input int exp_n, input string name);
        int   i       = 0;
        int   guard   = 0;
        int   bp_left = 0;
        bit   bp_done = 0;
        bit   got_done = 0;
        logic acc;
        cur_pat[d] = pat;
        clear_stats(d);
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        while (i < nbits && guard < 2 * nbits + 100) begin
            if (i == bp_at && !bp_done) begin
                bp_left = 10;
                bp_done = 1;
            end
            in_valid_s[d]  = 1'b1;
            in_bit_s[d]    = pix(pat, i);
            out_ready_s[d] = (bp_left == 0);
            start_s[d]     = (i == start_at);
            @(negedge clk);
            if (out_ready_s[d] && !in_ready_s[d]) rdy_err[d]++;
            if (!out_ready_s[d] && out_valid_s[d] && in_ready_s[d]) rdy_err[d]++;
            if (!out_ready_s[d] && !in_ready_s[d]) bp_low[d]++;
            acc = in_ready_s[d];
            @(posedge clk); #1;
            if (acc) i++;
            if (bp_left > 0) bp_left--;
            guard++;
        end
        in_valid_s[d]  = 1'b0;
        start_s[d]     = 1'b0;
        out_ready_s[d] = 1'b1;
        check({name, "_pixels_fed"}, i, nbits);
        for (int k = 0; k < 200 && !got_done; k++) begin
            @(negedge clk);
            if (done_s[d]) got_done = 1;
        end
        check({name, "_done_seen"}, got_done, 1);
        check({name, "_busy_after_done"}, busy_s[d], 0);
        check({name, "_in_ready_idle"}, in_ready_s[d], 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_word_count"}, n_words[d], exp_n);
        check({name, "_word_mismatches"}, mis[d], 0);
        check({name, "_run_sum"}, sum_len[d], nbits);
        check({name, "_zero_len_runs"}, zero_len[d], 0);
        check({name, "_done_pulses"}, done_cnt[d], 1);
        check({name, "_done_delay"}, done_at[d] - last_hs[d], 1);
        check({name, "_in_ready_rule"}, rdy_err[d], 0);
`ifdef RLE_WORD_COUNT_EN
        check({name, "_word_cnt"}, word_cnt_s[d], exp_n);
`endif
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n_s[d] = 1'b0; start_s[d] = 1'b0; in_valid_s[d] = 1'b0;
            in_bit_s[d] = 1'b0; out_ready_s[d] = 1'b1; cur_pat[d] = 0;
            prev_stall[d] = 1'b0; prev_word[d] = '0;
            clear_stats(d);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_in_ready", in_ready_s[d], 0);
            check("rst_out_valid", out_valid_s[d], 0);
            check("rst_out_word", out_word_s[d], 0);
            check("rst_busy", busy_s[d], 0);
            check("rst_done", done_s[d], 0);
`ifdef RLE_WORD_COUNT_EN
            check("rst_word_cnt", word_cnt_s[d], 0);
`endif
            rst_n_s[d] = 1'b1;
        end
        @(posedge clk); #1;

        fork
            begin
                run_frame(0, 0, 16384, -1, -1, 1, "zeros");
                run_frame(0, 2, 16384, 100, -1, 16384, "alt");
                check("alt_bp_in_ready_low", bp_low[0], 10);
                check("alt_bp_word_stable", stall_err[0], 0);
                check("alt_bp_stall_observed", stall_seen[0] >= 9, 1);
            end
            begin
                run_frame(1, 1, 40000, -1, -1, 2, "ones40k");
            end
            begin
                // Partial frame left pending in the output register, then reset.
                out_ready_s[2] = 1'b0;
                start_s[2] = 1'b1;
                @(posedge clk); #1;
                start_s[2] = 1'b0;
                in_valid_s[2] = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    in_bit_s[2] = (k < 2);
                    @(posedge clk); #1;
                end
                in_valid_s[2] = 1'b0;
                @(negedge clk);
                check("part_busy", busy_s[2], 1);
                check("part_word_pending", out_valid_s[2], 1);
                rst_n_s[2] = 1'b0;
                @(posedge clk); #1;
                check("midrst_out_valid", out_valid_s[2], 0);
                check("midrst_busy", busy_s[2], 0);
                rst_n_s[2] = 1'b1;
                out_ready_s[2] = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                check("postrst_idle_busy", busy_s[2], 0);
                check("postrst_no_word", out_valid_s[2], 0);
                check("postrst_in_ready", in_ready_s[2], 0);
                run_frame(2, 3, 16, -1, 4, 2, "restart16");
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
